led_fade_driver: RTL and testbench



---
 rtl/led_fade_driver.sv | 90 +++++++++
 tb/tb_led_fade_driver.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/led_fade_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_fade_driver: 8-channel PWM LED driver with per-channel brightness    |
// | ramping. Optional gamma duty curve via LED_FADE_GAMMA_EN.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module led_fade_driver #(
  parameter int PWM_DIV  = 4,
  parameter int STEP_DIV = 50000
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] led_readdata,
  input  logic       fade_en,
  output logic [7:0] led_o,
  output logic       busy
);

  localparam logic [15:0] PRE_LAST  = 16'(PWM_DIV - 1);
  localparam logic [23:0] STEP_LAST = 24'(STEP_DIV - 1);

  logic [7:0]  target;
  logic [23:0] step_cnt;
  logic [15:0] pre;
  logic [7:0]  pwm_cnt;
  logic [7:0]  level [8];
  logic [7:0]  led_next;
  logic [7:0]  mismatch;
  logic        tick;

  assign tick = (step_cnt == STEP_LAST);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      target   <= 8'h00;
      step_cnt <= 24'd0;
      pre      <= 16'd0;
      pwm_cnt  <= 8'd0;
    end else begin
      target   <= led_readdata;
      step_cnt <= tick ? 24'd0 : step_cnt + 24'd1;
      if (pre == PRE_LAST) begin
        pre     <= 16'd0;
        pwm_cnt <= pwm_cnt + 8'd1;
      end else begin
        pre     <= pre + 16'd1;
      end
    end
  end

  generate
    for (genvar i = 0; i < 8; i++) begin : g_ch
      logic [7:0] duty;

      // A tick coinciding with a target change sees the old registered target.
      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
          level[i] <= 8'd0;
        end else if (!fade_en) begin
          level[i] <= {8{target[i]}};
        end else if (tick) begin
          if (target[i] && level[i] != 8'hFF)
            level[i] <= level[i] + 8'd1;
          else if (!target[i] && level[i] != 8'h00)
            level[i] <= level[i] - 8'd1;
        end
      end

`ifdef LED_FADE_GAMMA_EN
      assign duty = 8'((16'(level[i]) * 16'(level[i])) >> 8);
`else
      assign duty = level[i];
`endif

      assign led_next[i] = (level[i] == 8'hFF) ? 1'b1 : (duty > pwm_cnt);
      assign mismatch[i] = (level[i] != {8{target[i]}});
    end
  endgenerate

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)
      led_o <= 8'h00;
    else
      led_o <= led_next;
  end

  assign busy = |mismatch;

endmodule
`default_nettype wire

// File: tb/tb_led_fade_driver.sv
`default_nettype none
// Directed bench for led_fade_driver: fast-ramp instance (STEP_DIV=4) and a
// slow-ramp instance (STEP_DIV=300) for duty-cycle measurement.
module tb_led_fade_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rd, rd3;
  logic       fade_en;
  logic [7:0] led, led3;
  logic       busy, busy3;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         highs;

  always #5 clk = ~clk;

  led_fade_driver #(.PWM_DIV(1), .STEP_DIV(4)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .led_readdata(rd),
    .fade_en(fade_en), .led_o(led), .busy(busy)
  );

  led_fade_driver #(.PWM_DIV(1), .STEP_DIV(300)) dut3 (
    .clk_clk(clk), .reset_reset_n(rst_n), .led_readdata(rd3),
    .fade_en(fade_en), .led_o(led3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Release reset just after an edge; the next edge is edge 1.
  task automatic release_rst(input logic [7:0] v);
    rd    = v;
    rst_n = 1'b1;
  endtask

  task automatic hold_rst();
    rst_n = 1'b0;
    step(2);
  endtask

  initial begin
    rst_n   = 1'b0;
    rd      = 8'hFF;
    rd3     = 8'hFF;
    fade_en = 1'b1;

    // Reset with all-ones input: outputs stay quiet.
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("rst_led", led, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_led3", led3, 8'h00);
      chk("rst_busy3", busy3, 1'b0);
    end

    // Slow instance ramps bit 0; level is 64 over edges 19200..19499.
    rd3 = 8'h01;
    release_rst(8'h00);
    step(1);
    chk("t3_busy_rise", busy3, 1'b1);
    chk("t3_idle_busy", busy, 1'b0);
    step(19218);
    highs = 0;
    for (int k = 0; k < 256; k++) begin
      step(1);
      highs += int'(led3[0]);
    end
`ifdef LED_FADE_GAMMA_EN
    chk("t3_duty64", highs, 16);
`else
    chk("t3_duty64", highs, 64);
`endif
    chk("t3_upper_off", led3[7:1], 7'h00);
    chk("t3_busy_mid", busy3, 1'b1);

    // Full ramp of bit 0: level 255 after edge 1020.
    hold_rst();
    release_rst(8'h01);
    chk("t2_busy_before", busy, 1'b0);
    step(1);
    chk("t2_busy_rise", busy, 1'b1);
    for (int k = 2; k <= 1019; k++) begin
      step(1);
      chk("t2_upper_off", led[7:1], 7'h00);
    end
    chk("t2_busy_1019", busy, 1'b1);
    step(1);
    chk("t2_busy_1020", busy, 1'b0);
    for (int k = 0; k < 300; k++) begin
      step(1);
      chk("t2_full_on", led, 8'h01);
    end

    // Reset mid-ramp (level 128), then a full ramp from 0.
    hold_rst();
    release_rst(8'h01);
    step(514);
    chk("t6_led_mid", led, 8'h01);
    chk("t6_busy_mid", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_led_async", led, 8'h00);
    chk("t6_busy_async", busy, 1'b0);
    step(1);
    release_rst(8'h01);
    step(1019);
    chk("t6_busy_1019", busy, 1'b1);
    step(1);
    chk("t6_busy_1020", busy, 1'b0);
    step(1);
    chk("t6_full_on", led, 8'h01);

    // Bit 3 rises to 100, then falls back: level 0 after edge 800.
    hold_rst();
    release_rst(8'h08);
    step(400);
    chk("t4_busy_peak", busy, 1'b1);
    rd = 8'h00;
    step(399);
    chk("t4_busy_799", busy, 1'b1);
    step(1);
    chk("t4_busy_800", busy, 1'b0);
    for (int k = 0; k < 40; k++) begin
      step(1);
      chk("t4_led_off", led, 8'h00);
      chk("t4_busy_off", busy, 1'b0);
    end

    // Snap mode: input to output in exactly 3 edges, busy for 1 cycle.
    fade_en = 1'b0;
    hold_rst();
    release_rst(8'h00);
    step(10);
    chk("t5_busy_idle", busy, 1'b0);
    rd = 8'hA5;
    step(1);
    chk("t5_busy_e1", busy, 1'b1);
    chk("t5_led_e1", led, 8'h00);
    step(1);
    chk("t5_busy_e2", busy, 1'b0);
    chk("t5_led_e2", led, 8'h00);
    step(1);
    chk("t5_led_e3", led, 8'hA5);
    chk("t5_busy_e3", busy, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step(1);
      chk("t5_led_hold", led, 8'hA5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
